// File: rtl/chngy_fetch_ctrl.sv
// Change-in-Y sequencer: walks Y_ii, Y_jj, Y_ij, Y_ji through read, calc and write-back.
// Latency: 3 cycles + calc time per element. Accepts a new record only when idle (chg_ready).
module chngy_fetch_ctrl #(
    parameter int N_BUS   = 4,
    parameter int ADDR_W  = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              chg_valid,
    output logic              chg_ready,
    input  logic [IDX_W-1:0]  chg_row,
    input  logic [IDX_W-1:0]  chg_col,
    input  logic [47:0]       chg_dy,
    output logic              ymem_rd_en,
    output logic [ADDR_W-1:0] ymem_rd_addr,
    input  logic [47:0]       ymem_rd_data,
    output logic              ymem_wr_en,
    output logic [ADDR_W-1:0] ymem_wr_addr,
    output logic [47:0]       ymem_wr_data,
    output logic              calc_en,
    output logic [47:0]       calc_y1,
    output logic [47:0]       calc_y2,
    input  logic              calc_done,
    input  logic [47:0]       calc_result,
    output logic              busy,
    output logic              upd_done,
    output logic              err_range,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]    LP_NB_IDX = N_BUS[IDX_W:0];
    localparam logic [ADDR_W-1:0] LP_NB_ADR = N_BUS[ADDR_W-1:0];
    localparam logic [CNT_W-1:0]  LP_TMAX   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_EXEC, S_WB} state_t;

    state_t             r_state, w_next;
    logic [IDX_W-1:0]   r_row, r_col;
    logic [47:0]        r_dy, r_y1, r_y2, r_res;
    logic [1:0]         r_k;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready, r_upd_done, r_err_range, r_err_tmo;

    logic               w_accept, w_in_range, w_last, w_tmo;
    logic [IDX_W-1:0]   w_erow, w_ecol;
    logic [ADDR_W-1:0]  w_addr;
    logic [47:0]        w_dy_sel;

    // Saturating two's-complement negate of one 24-bit half.
    function automatic logic [23:0] neg24(input logic [23:0] v);
        return (v == 24'h800000) ? 24'h7FFFFF : (~v + 24'd1);
    endfunction

    assign w_accept   = chg_valid && r_ready && (r_state == S_IDLE);
    assign w_in_range = ({1'b0, chg_row} < LP_NB_IDX) && ({1'b0, chg_col} < LP_NB_IDX);
    assign w_last     = (r_row == r_col) || (r_k == 2'd3);
    assign w_tmo      = (r_state == S_EXEC) && !calc_done && (r_cnt == LP_TMAX);

    // k0 (i,i), k1 (j,j), k2 (i,j), k3 (j,i); off-diagonal elements take -dy.
    assign w_erow   = (r_k == 2'd1 || r_k == 2'd3) ? r_col : r_row;
    assign w_ecol   = (r_k == 2'd0 || r_k == 2'd3) ? r_row : r_col;
    assign w_addr   = ADDR_W'(w_erow) * LP_NB_ADR + ADDR_W'(w_ecol);
    assign w_dy_sel = r_k[1] ? {neg24(r_dy[47:24]), neg24(r_dy[23:0])} : r_dy;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_in_range) w_next = S_RD;
            S_RD:   w_next = S_WAIT;
            S_WAIT: w_next = S_EXEC;
            S_EXEC: begin
                if (calc_done)  w_next = S_WB;
                else if (w_tmo) w_next = S_IDLE;
            end
            S_WB:   w_next = w_last ? S_IDLE : S_RD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_dy        <= '0;
            r_y1        <= '0;
            r_y2        <= '0;
            r_res       <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_upd_done  <= 1'b0;
            r_err_range <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ready     <= (w_next == S_IDLE);
            r_upd_done  <= (r_state == S_WB) && w_last;
            r_err_range <= w_accept && !w_in_range;
            r_err_tmo   <= w_tmo;
            r_cnt       <= (r_state == S_EXEC) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_row <= chg_row;
                r_col <= chg_col;
                r_dy  <= chg_dy;
                r_k   <= 2'd0;
            end
            if (r_state == S_WAIT) begin
                r_y1 <= ymem_rd_data;
                r_y2 <= w_dy_sel;
            end
            if (r_state == S_EXEC && calc_done) r_res <= calc_result;
            if (r_state == S_WB && !w_last) r_k <= r_k + 2'd1;
        end
    end

    assign chg_ready    = r_ready;
    assign busy         = (r_state != S_IDLE);
    assign ymem_rd_en   = (r_state == S_RD);
    assign ymem_rd_addr = ymem_rd_en ? w_addr : '0;
    assign ymem_wr_en   = (r_state == S_WB);
    assign ymem_wr_addr = ymem_wr_en ? w_addr : '0;
    assign ymem_wr_data = ymem_wr_en ? r_res : '0;
    assign calc_en      = (r_state == S_EXEC);
    assign calc_y1      = r_y1;
    assign calc_y2      = r_y2;
    assign upd_done     = r_upd_done;
    assign err_range    = r_err_range;
    assign err_timeout  = r_err_tmo;

endmodule
